// File: rtl/pxs_digit_scheduler_if.sv
// Load/increment handshake between a score source and the digit scheduler.
// The master drives the load request and increment pulse. The slave returns ld_ready.
interface pxs_digit_scheduler_if #(
    parameter int unsigned NDIGITS = 4
);
    logic                   ld_valid;
    logic [4*NDIGITS-1:0]   ld_data;
    logic                   ld_ready;
    logic                   inc;

    modport master (output ld_valid, output ld_data, output inc, input ld_ready);
    modport slave  (input ld_valid, input ld_data, input inc, output ld_ready);
endinterface

// File: rtl/pxs_digit_scheduler.sv
// Shares one digit renderer across NDIGITS horizontal slots of a BCD score display.
// Stream layout: XC in RGBStr_i[25:16], YC in RGBStr_i[15:6], colour/sync in [5:0].
module pxs_digit_scheduler #(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned BASE_X  = 16,
    parameter int unsigned BASE_Y  = 16,
    parameter int unsigned PITCH   = 40
) (
    input  logic                  px_clk,
    input  logic                  reset_n,
    input  logic [25:0]           RGBStr_i,
    pxs_digit_scheduler_if.slave  ld,
    output logic [4*NDIGITS-1:0]  value_o,
    output logic                  ovf,
    output logic [3:0]            number,
    output logic [9:0]            pos_x,
    output logic [9:0]            pos_y
);
    localparam int unsigned XC_LSB = 16;
    localparam int unsigned YC_LSB = 6;
    localparam int unsigned W      = 4 * NDIGITS;

    logic [9:0]   xc;
    logic [9:0]   yc;
    logic         fs;
    logic         ld_fire;
    logic [31:0]  nx;
    logic         all_nines;
    logic         carry;
    logic [W-1:0] cnt_inc;
    logic         unused_stream;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] disp_q, disp_d;
    logic         pend_q, pend_d;
    logic         ovf_q, ovf_d;
    logic [3:0]   number_q, number_d;
    logic [9:0]   pos_x_q, pos_x_d;
    logic [9:0]   pos_y_q, pos_y_d;

    assign xc            = RGBStr_i[XC_LSB +: 10];
    assign yc            = RGBStr_i[YC_LSB +: 10];
    assign unused_stream = ^RGBStr_i[YC_LSB-1:0];
    assign fs            = (xc == 10'd0) && (yc == 10'd0);
    assign ld_fire       = ld.ld_valid && !pend_q;
    assign nx            = 32'(xc) + 32'd1;

    // Ripple from the least significant digit (low nibble); nibbles >= 9 wrap to 0 with carry.
    always_comb begin
        all_nines = 1'b1;
        carry     = 1'b1;
        cnt_inc   = cnt_q;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (cnt_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (cnt_q[4*i +: 4] >= 4'd9) begin
                    cnt_inc[4*i +: 4] = '0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        pend_d = pend_q;
        disp_d = disp_q;
        if (ld_fire) begin
            cnt_d  = ld.ld_data;
            ovf_d  = 1'b0;
            pend_d = 1'b1;
        end else if (ld.inc) begin
            if (all_nines) ovf_d = 1'b1;
            else           cnt_d = cnt_inc;
        end
        // Commit sees this cycle's load/increment so nothing is lost at the frame boundary.
        if (fs) begin
            disp_d = cnt_d;
            pend_d = 1'b0;
        end
    end

    // Decode for the pixel that reaches the renderer next cycle (XC+1).
    always_comb begin
        number_d = number_q;
        pos_x_d  = '1;
        pos_y_d  = 10'(BASE_Y);
        for (int unsigned k = 0; k < NDIGITS; k++) begin
            int unsigned lo;
            lo = BASE_X + k * PITCH;
            if ((nx >= lo) && (nx < lo + PITCH)) begin
                number_d = disp_q[4*(NDIGITS-1-k) +: 4];
                pos_x_d  = lo[9:0];
            end
        end
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            number_q <= '0;
            pos_x_q  <= '1;
            pos_y_q  <= 10'(BASE_Y);
        end else begin
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            number_q <= number_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
        end
    end

    assign ld.ld_ready = !pend_q;
    assign value_o     = cnt_q;
    assign ovf         = ovf_q;
    assign number      = number_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
endmodule

// File: tb/tb_pxs_digit_scheduler.sv
// Scoreboard bench for pxs_digit_scheduler: drivers queue hand-computed expectations
// tagged with a target cycle, a negedge monitor pops and compares them.
module tb_pxs_digit_scheduler;
    localparam int unsigned ND = 4;

    logic        px_clk  = 1'b0;
    logic        reset_n = 1'b0;
    logic [25:0] rgb     = '0;
    logic [15:0] value_o;
    logic        ovf;
    logic [3:0]  number;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;

    pxs_digit_scheduler_if #(.NDIGITS(ND)) lif ();

    pxs_digit_scheduler #(
        .NDIGITS(ND),
        .BASE_X (16),
        .BASE_Y (16),
        .PITCH  (40)
    ) dut (
        .px_clk  (px_clk),
        .reset_n (reset_n),
        .RGBStr_i(rgb),
        .ld      (lif),
        .value_o (value_o),
        .ovf     (ovf),
        .number  (number),
        .pos_x   (pos_x),
        .pos_y   (pos_y)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        bit          pix;
        logic [9:0]  px;
        logic [3:0]  num;
        bit          val;
        logic [15:0] v;
        logic        o;
        logic        r;
        int unsigned tgt;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc_n  = 0;

    logic [15:0] shown    = '0;
    logic [15:0] commit   = '0;
    logic [3:0]  last_num = '0;
    bit          ldv      = 1'b0;
    logic [15:0] ldd      = '0;
    bit          incv     = 1'b0;

    always @(posedge px_clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    always @(negedge px_clk) begin
        while (q.size() > 0 && q[0].tgt <= cyc_n) begin
            mon_e = q.pop_front();
            if (mon_e.pix) begin
                check("pos_x",  32'(pos_x),  32'(mon_e.px));
                check("number", 32'(number), 32'(mon_e.num));
                check("pos_y",  32'(pos_y),  32'd16);
            end
            if (mon_e.val) begin
                check("value_o",  32'(value_o),      32'(mon_e.v));
                check("ovf",      32'(ovf),          32'(mon_e.o));
                check("ld_ready", 32'(lif.ld_ready), 32'(mon_e.r));
            end
        end
    end

    // One pixel: drive, queue expected renderer outputs for the next edge, advance.
    task automatic cyc(input int x, input int y);
        exp_t        e;
        int          nx;
        int          k;
        logic [9:0]  xv;
        logic [9:0]  yv;
        logic        rdy;
        xv = x[9:0];
        yv = y[9:0];
        if (x == 0 && y == 0) shown = commit;
        rgb          = {xv, yv, 6'b0};
        lif.ld_valid = ldv;
        lif.ld_data  = ldd;
        lif.inc      = incv;
        e.pix = 1'b1;
        e.val = 1'b0;
        e.v   = '0;
        e.o   = 1'b0;
        e.r   = 1'b0;
        nx    = x + 1;
        if (nx >= 16 && nx < 176) begin
            k        = (nx - 16) / 40;
            e.px     = 10'(16 + 40 * k);
            e.num    = 4'((shown >> (4 * (3 - k))) & 16'hF);
            last_num = e.num;
        end else begin
            e.px  = 10'h3FF;
            e.num = last_num;
        end
        e.tgt = cyc_n + 1;
        q.push_back(e);
        rdy = lif.ld_ready;
        @(posedge px_clk);
        #1;
        if (ldv && rdy) ldv = 1'b0;
        incv = 1'b0;
    endtask

    task automatic chk_val(input logic [15:0] v, input logic o, input logic r);
        exp_t e;
        e.pix = 1'b0;
        e.px  = '0;
        e.num = '0;
        e.val = 1'b1;
        e.v   = v;
        e.o   = o;
        e.r   = r;
        e.tgt = cyc_n;
        q.push_back(e);
    endtask

    task automatic run(input int y, input int a, input int b);
        for (int x = a; x <= b; x++) cyc(x, y);
    endtask

    task automatic rest_frame(input int a);
        run(0, a, 199);
        run(1, 0, 199);
    endtask

    task automatic load(input logic [15:0] d);
        ldv = 1'b1;
        ldd = d;
    endtask

    initial begin
        int w;
        lif.ld_valid = 1'b0;
        lif.ld_data  = '0;
        lif.inc      = 1'b0;
        repeat (3) @(posedge px_clk);
        #1;
        check("rst_value_o",  32'(value_o),      32'h0);
        check("rst_ovf",      32'(ovf),          32'h0);
        check("rst_ld_ready", 32'(lif.ld_ready), 32'h1);
        check("rst_number",   32'(number),       32'h0);
        check("rst_pos_x",    32'(pos_x),        32'h3FF);
        check("rst_pos_y",    32'(pos_y),        32'd16);
        reset_n = 1'b1;
        chk_val(16'h0000, 1'b0, 1'b1);

        // Frame 0: zeros everywhere, slot edges at XC 15/55/95/135/175.
        rest_frame(0);

        // Frame 1: mid-frame load, display unchanged until next frame start.
        run(0, 0, 49);
        load(16'h1234);
        cyc(50, 0);
        chk_val(16'h1234, 1'b0, 1'b0);
        rest_frame(51);

        // Frame 2: 1234 shown; first load accepted, second one held back.
        commit = 16'h1234;
        cyc(0, 0);
        chk_val(16'h1234, 1'b0, 1'b1);
        run(0, 1, 19);
        load(16'h1111);
        cyc(20, 0);
        chk_val(16'h1111, 1'b0, 1'b0);
        load(16'h5678);
        cyc(21, 0);
        chk_val(16'h1111, 1'b0, 1'b0);
        rest_frame(22);

        // Frame 3: held load lands right after frame start.
        commit = 16'h1111;
        cyc(0, 0);
        chk_val(16'h1111, 1'b0, 1'b1);
        cyc(1, 0);
        chk_val(16'h5678, 1'b0, 1'b0);
        rest_frame(2);

        // Frame 4: 0199 + 1 ripples to 0200.
        commit = 16'h5678;
        cyc(0, 0);
        run(0, 1, 9);
        load(16'h0199);
        cyc(10, 0);
        chk_val(16'h0199, 1'b0, 1'b0);
        incv = 1'b1;
        cyc(11, 0);
        chk_val(16'h0200, 1'b0, 1'b0);
        rest_frame(12);

        // Frame 5: 9999 + 1 saturates and sets ovf.
        commit = 16'h0200;
        cyc(0, 0);
        load(16'h9999);
        cyc(1, 0);
        chk_val(16'h9999, 1'b0, 1'b0);
        incv = 1'b1;
        cyc(2, 0);
        chk_val(16'h9999, 1'b1, 1'b0);
        rest_frame(3);

        // Frame 6: load+inc together, load wins and clears ovf; later inc still counts.
        commit = 16'h9999;
        cyc(0, 0);
        load(16'h0007);
        incv = 1'b1;
        cyc(1, 0);
        chk_val(16'h0007, 1'b0, 1'b0);
        incv = 1'b1;
        cyc(2, 0);
        chk_val(16'h0008, 1'b0, 1'b0);
        rest_frame(3);

        // Frame 7: non-BCD nibble wraps with carry: 00A9 + 1 = 0100.
        commit = 16'h0008;
        cyc(0, 0);
        load(16'h00A9);
        cyc(1, 0);
        chk_val(16'h00A9, 1'b0, 1'b0);
        incv = 1'b1;
        cyc(2, 0);
        chk_val(16'h0100, 1'b0, 1'b0);
        rest_frame(3);

        // Frame 8: load 4321 for display in frame 9.
        commit = 16'h0100;
        cyc(0, 0);
        load(16'h4321);
        cyc(1, 0);
        chk_val(16'h4321, 1'b0, 1'b0);
        rest_frame(2);

        // Frame 9: reset asserted mid-line while 4321 is shown.
        commit = 16'h4321;
        run(0, 0, 100);
        @(negedge px_clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_value_o",  32'(value_o),      32'h0);
        check("mid_rst_ovf",      32'(ovf),          32'h0);
        check("mid_rst_ld_ready", 32'(lif.ld_ready), 32'h1);
        check("mid_rst_number",   32'(number),       32'h0);
        check("mid_rst_pos_x",    32'(pos_x),        32'h3FF);
        check("mid_rst_pos_y",    32'(pos_y),        32'd16);
        shown    = '0;
        commit   = '0;
        last_num = '0;
        ldv      = 1'b0;
        incv     = 1'b0;
        @(posedge px_clk);
        #1;
        reset_n = 1'b1;
        chk_val(16'h0000, 1'b0, 1'b1);
        run(0, 101, 199);
        run(1, 0, 199);

        // Frame 10: zeros after reset.
        rest_frame(0);

        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(posedge px_clk);
            w++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
